// File: rtl/microrisc_trace_pkg.sv
// Shared definitions for the writeback trace logger: FSM encoding,
// entry field layout {pc, addr, data} and counter sizing.
package microrisc_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } trace_state_e;

    function automatic int entry_w(input int pc_w, input int raddr_w, input int data_w);
        return pc_w + raddr_w + data_w;
    endfunction

    function automatic int data_lsb();
        return 0;
    endfunction

    function automatic int addr_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int pc_lsb(input int raddr_w, input int data_w);
        return data_w + raddr_w;
    endfunction

    // One extra bit so a completely full buffer (count == depth) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/trace_buffer.sv
// Circular entry store with head/tail/count; push writes at tail, pop
// retires head, push+overwrite drops the oldest entry while count holds.
module trace_buffer #(
    parameter int DEPTH = 16,
    parameter int EW    = 35
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     overwrite,
    input  logic [EW-1:0]            wdata,
    output logic [EW-1:0]            head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] head_q, tail_q;
    logic [AW:0]   count_q;

    always_ff @(posedge clk) begin
        if (push)
            mem[tail_q] <= wdata;
    end

    // Push and pop come from different FSM states and never coincide.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (push) begin
            tail_q <= tail_q + AW'(1);
            if (overwrite)
                head_q <= head_q + AW'(1);
            else
                count_q <= count_q + (AW+1)'(1);
        end else if (pop) begin
            head_q  <= head_q + AW'(1);
            count_q <= count_q - (AW+1)'(1);
        end
    end

    assign head_data = mem[head_q];
    assign count     = count_q;

endmodule

// File: rtl/debug_trace_capture.sv
// Writeback trace logger: captures filtered register-write events, then
// drains them oldest-first over valid/ready. MICRORISC_TRACE_WRAP_EN selects wrap-on-full.
module debug_trace_capture
    import microrisc_trace_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int PC_W    = 16,
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PC_W-1:0]                   trace_pc,
    input  logic                              trace_wr_en,
    input  logic [RADDR_W-1:0]                trace_wr_addr,
    input  logic [DATA_W-1:0]                 trace_wr_data,
    input  logic                              cfg_arm,
    input  logic                              cfg_stop,
    input  logic                              filter_en,
    input  logic [RADDR_W-1:0]                filter_reg,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic [PC_W+RADDR_W+DATA_W-1:0]    rd_data,
    output logic                              capturing,
    output logic [cnt_w(DEPTH)-1:0]           count,
    output logic                              overflow
);

    localparam int EW = entry_w(PC_W, RADDR_W, DATA_W);
    localparam int CW = cnt_w(DEPTH);
    localparam int DL = data_lsb();
    localparam int AL = addr_lsb(DATA_W);
    localparam int PL = pc_lsb(RADDR_W, DATA_W);

    trace_state_e state_q, state_d;

    logic          accept, full;
    logic          push, pop, ovw, clr;
    logic [EW-1:0] wdata, head_data;

    assign wdata[DL +: DATA_W]  = trace_wr_data;
    assign wdata[AL +: RADDR_W] = trace_wr_addr;
    assign wdata[PL +: PC_W]    = trace_pc;

    assign accept = trace_wr_en && (!filter_en || (trace_wr_addr == filter_reg));
    assign full   = (count == CW'(DEPTH));

    trace_buffer #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .push      (push),
        .pop       (pop),
        .overwrite (ovw),
        .wdata     (wdata),
        .head_data (head_data),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        pop      = 1'b0;
        ovw      = 1'b0;
        clr      = 1'b0;
        rd_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_arm) begin
                    clr     = 1'b1;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
`ifdef MICRORISC_TRACE_WRAP_EN
                if (accept) begin
                    push = 1'b1;
                    ovw  = full;
                end
`else
                // The edge that fills the last slot also ends capture.
                if (accept && !full) begin
                    push = 1'b1;
                    if (count == CW'(DEPTH - 1))
                        state_d = ST_DRAIN;
                end
`endif
                if (cfg_stop)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                rd_valid = (count != '0);
                if (rd_valid && rd_ready) begin
                    pop = 1'b1;
                    if (count == CW'(1))
                        state_d = ST_IDLE;
                end
                if (count == '0)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rd_data   = rd_valid ? head_data : '0;
    assign capturing = (state_q == ST_CAPTURE);

`ifdef MICRORISC_TRACE_WRAP_EN
    logic overflow_q;

    always_ff @(posedge clk) begin
        if (rst || clr)
            overflow_q <= 1'b0;
        else if (ovw)
            overflow_q <= 1'b1;
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_debug_trace_capture.sv
// Scoreboard bench for debug_trace_capture (DEPTH=4): stimulus pushes expected
// entries into a queue, a negedge monitor pops and compares on each transfer.
module tb_debug_trace_capture;

    localparam int DEPTH = 4;
    localparam int PC_W = 16, DATA_W = 16, RADDR_W = 3;
    localparam int EW = PC_W + RADDR_W + DATA_W;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [PC_W-1:0]    trace_pc = '0;
    logic               trace_wr_en = 1'b0;
    logic [RADDR_W-1:0] trace_wr_addr = '0;
    logic [DATA_W-1:0]  trace_wr_data = '0;
    logic               cfg_arm = 1'b0, cfg_stop = 1'b0;
    logic               filter_en = 1'b0;
    logic [RADDR_W-1:0] filter_reg = '0;
    logic               rd_valid, rd_ready = 1'b0;
    logic [EW-1:0]      rd_data;
    logic               capturing, overflow;
    logic [2:0]         count;

    int n_tests = 0, n_fail = 0;
    logic [EW-1:0] exp_q[$];
    bit m_cap = 0;

    debug_trace_capture #(
        .DEPTH(DEPTH), .PC_W(PC_W), .DATA_W(DATA_W), .RADDR_W(RADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .trace_pc(trace_pc), .trace_wr_en(trace_wr_en),
        .trace_wr_addr(trace_wr_addr), .trace_wr_data(trace_wr_data),
        .cfg_arm(cfg_arm), .cfg_stop(cfg_stop), .filter_en(filter_en),
        .filter_reg(filter_reg), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .capturing(capturing), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: a transfer happens on the next posedge whenever valid&ready now.
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            if (exp_q.size() == 0)
                chk("unexpected_entry", 64'(rd_data), 64'hDEAD);
            else
                chk("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm();
        cfg_arm = 1'b1;
        tick();
        cfg_arm = 1'b0;
        m_cap = 1;
    endtask

    task automatic stop();
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        m_cap = 0;
    endtask

    // Drive one event; the model decides acceptance and buffer contents.
    task automatic ev(input logic [15:0] pc, input logic [2:0] a, input logic [15:0] d);
        trace_pc = pc; trace_wr_addr = a; trace_wr_data = d; trace_wr_en = 1'b1;
        if (m_cap && (!filter_en || a == filter_reg)) begin
            if (exp_q.size() == DEPTH) begin
`ifdef MICRORISC_TRACE_WRAP_EN
                void'(exp_q.pop_front());
                exp_q.push_back({pc, a, d});
`endif
            end else begin
                exp_q.push_back({pc, a, d});
`ifndef MICRORISC_TRACE_WRAP_EN
                if (exp_q.size() == DEPTH) m_cap = 0;
`endif
            end
        end
        tick();
        trace_wr_en = 1'b0;
    endtask

    task automatic drain(input string nm);
        rd_ready = 1'b1;
        for (int i = 0; i < 20 && rd_valid; i++) tick();
        chk({nm, "_valid_low"}, 64'(rd_valid), 64'd0);
        chk({nm, "_all_seen"}, 64'(exp_q.size()), 64'd0);
        chk({nm, "_count0"}, 64'(count), 64'd0);
        chk({nm, "_idle"}, 64'(capturing), 64'd0);
        rd_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_valid", 64'(rd_valid), 64'd0);
        chk("rst_data", 64'(rd_data), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_capturing", 64'(capturing), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;

        // 1: basic capture then drain
        arm();
        chk("t1_capturing", 64'(capturing), 64'd1);
        ev(16'h0004, 3'd1, 16'h0011);
        ev(16'h0006, 3'd2, 16'h0022);
        ev(16'h0008, 3'd1, 16'h0033);
        chk("t1_count", 64'(count), 64'd3);
        chk("t1_head_q", 64'(exp_q[0]), 64'({16'h0004, 3'd1, 16'h0011}));
        stop();
        drain("t1");

        // 2/3: six events into a four-entry buffer
        arm();
        for (int i = 1; i <= 6; i++) begin
            ev(16'(i * 2), 3'd1, 16'(i));
            if (i == 4) begin
`ifdef MICRORISC_TRACE_WRAP_EN
                chk("t3_still_capturing", 64'(capturing), 64'd1);
`else
                chk("t2_autostop", 64'(capturing), 64'd0);
`endif
            end
        end
        chk("t2_count_full", 64'(count), 64'd4);
`ifdef MICRORISC_TRACE_WRAP_EN
        chk("t3_overflow", 64'(overflow), 64'd1);
        chk("t3_oldest", 64'(exp_q[0][15:0]), 64'd3);
`else
        chk("t2_overflow", 64'(overflow), 64'd0);
        chk("t2_oldest", 64'(exp_q[3][15:0]), 64'd4);
`endif
        stop();
        drain("t2");
        arm();
        chk("t3_arm_clears_ovf", 64'(overflow), 64'd0);
        chk("t3_arm_count", 64'(count), 64'd0);
        stop();
        tick();

        // 4: register filter
        filter_en = 1'b1; filter_reg = 3'd3;
        arm();
        ev(16'h0100, 3'd2, 16'h000A);
        ev(16'h0102, 3'd3, 16'h000B);
        ev(16'h0104, 3'd5, 16'h000C);
        ev(16'h0106, 3'd3, 16'h000D);
        chk("t4_count", 64'(count), 64'd2);
        stop();
        filter_en = 1'b0;
        drain("t4");

        // 5: backpressure
        arm();
        ev(16'h0200, 3'd4, 16'h0051);
        ev(16'h0202, 3'd5, 16'h0052);
        ev(16'h0204, 3'd6, 16'h0053);
        stop();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_stall_valid", 64'(rd_valid), 64'd1);
            chk("t5_stall_data", 64'(rd_data), 64'({16'h0200, 3'd4, 16'h0051}));
            chk("t5_stall_count", 64'(count), 64'd3);
        end
        for (int i = 0; i < 20 && rd_valid; i++) begin
            rd_ready = ~rd_ready;
            tick();
            chk("t5_count_track", 64'(count), 64'(exp_q.size()));
        end
        drain("t5");

        // 6: reset mid-drain, then clean restart
        arm();
        ev(16'h0300, 3'd1, 16'h0061);
        ev(16'h0302, 3'd1, 16'h0062);
        ev(16'h0304, 3'd1, 16'h0063);
        stop();
        chk("t6_pre_count", 64'(count), 64'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        chk("t6_valid", 64'(rd_valid), 64'd0);
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_capturing", 64'(capturing), 64'd0);
        arm();
        chk("t6_rearm", 64'(capturing), 64'd1);
        ev(16'h0400, 3'd7, 16'h0071);
        stop();
        drain("t6");

        // Stop with empty buffer: DRAIN falls back to IDLE, so arm works again
        arm();
        stop();
        tick();
        arm();
        chk("empty_drain_rearm", 64'(capturing), 64'd1);
        stop();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
